prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader for the single-cycle RISC-V core. It receives a byte stream over a valid/ready interface, assembles little-endian 32-bit instruction words and writes them into instruction memory. It holds the core in reset until the whole image is written. It sits between the host/bench byte source and the imem write port, and replaces the bench's fixed reset pulse as the mechanism that releases the core.

## Interface
Parameters:
- ADDR_W, 8, imem word-address width; the maximum image is 2^ADDR_W words.
- BASE_ADDR, 0, word address of the first write.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse that begins a load. Honoured in IDLE, DONE and ERR. Ignored while a load is in progress.
- in_valid  in  1  byte source has data.
- in_data  in  8  byte value.
- in_ready  out  1  loader accepts a byte.
- imem_we  out  1  imem write strobe, one cycle per word.
- imem_addr  out  ADDR_W  imem word address.
- imem_wdata  out  32  assembled instruction word.
- core_rst  out  1  active-high reset to the core.
- busy  out  1  a load is in progress.
- done  out  1  the image loaded successfully; the core is running.
- err  out  1  the header is invalid; the core stays in reset.

## Operation
- Stream format:
  - Byte 0: N[7:0]. Byte 1: N[15:8]. N is the word count.
  - Then 4N data bytes, least-significant byte first per word.
- States: IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR.
- IDLE:
  - On start, go to HDR0.
  - Clear the word counter; set imem_addr = BASE_ADDR.
- HDR0: in_ready=1. On a byte transfer, latch N[7:0] and go to HDR1.
- HDR1: in_ready=1. On a byte transfer, latch N[15:8], then branch:
  - N == 0: go to DONE.
  - BASE_ADDR + N > 2^ADDR_W: go to ERR. Compute this at ADDR_W+17 bits so it cannot overflow.
  - Otherwise: go to DATA.
- DATA:
  - in_ready=1.
  - Each transfer shifts the byte into position byte_cnt; byte_cnt is 2 bits.
  - On the 4th byte, go to WRITE.
- WRITE:
  - in_ready=0, imem_we=1, with imem_wdata and imem_addr stable.
  - Next cycle: imem_addr increments and word_cnt increments.
  - If word_cnt+1 == N, go to DONE; else go to DATA.
- DONE: core_rst=0, done=1.
- ERR: err=1, core_rst=1.
- start in DONE or ERR:
  - Reasserts core_rst on the next cycle.
  - Clears done/err and enters HDR0.
- busy=1 in HDR0, HDR1, DATA and WRITE.
- A byte transfer occurs only when in_valid && in_ready in the same cycle. in_valid low stalls the FSM indefinitely with no timeout.
- Bytes offered in IDLE, WRITE, DONE or ERR are not accepted (in_ready=0).

## Timing
- Reset values (asynchronous, while rst=0): state=IDLE, in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, core_rst=1, busy=0, done=0, err=0.
- Reset asserted mid-load aborts immediately. Words already written stay in imem; the loader restarts from IDLE.
- All outputs are registered or decoded from registered state; there are no combinational in→out paths.
- Best-case throughput: 5 cycles per word (4 accept cycles + 1 WRITE cycle).
- Latency from the last data byte accepted to imem_we: 1 cycle. core_rst falls 1 cycle after the final WRITE cycle.
- Header latency: the cycle after the second header byte is the first DATA cycle. With N=0, it is DONE.
- Maximum image: N = 2^ADDR_W − BASE_ADDR. The final write goes to address 2^ADDR_W−1, and imem_addr then wraps to 0 without being used.

## Structure
- Package prog_loader_pkg holds:
  - the state enum type;
  - HDR_BYTES=2 and WORD_BYTES=4 constants;
  - the N width localparam (16).
- One sub-module, byte_assembler. It holds the 32-bit shift/insert register and the 2-bit byte counter. Its outputs are the word and a word_ready pulse; its inputs are byte_valid, byte and clear.
- The top FSM, counters and address generation live in prog_loader.

## Test plan
- N=2, bytes 02 00 13 05 A0 00 93 05 B0 00, with in_valid held high:
  - imem_we pulses at addr 0 with 00A00513, then at addr 1 with 00B00593;
  - core_rst falls; done=1.
- Same stream with in_valid low for 3 random cycles between bytes: identical writes and identical data; no byte is lost or duplicated.
- N=0 (bytes 00 00): no imem_we; DONE the cycle after the second byte; core_rst=0.
- ADDR_W=4, N=17: err=1, no imem_we, core_rst stays 1. A following start with a valid N=1 image recovers to done=1.
- rst asserted after 6 data bytes of an N=2 load:
  - all outputs return to their reset values asynchronously;
  - a subsequent full load writes addr 0 and addr 1 correctly.
- start pulsed while in DATA: ignored, and the load completes normally.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

    localparam int unsigned HDR_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned N_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR0  = 3'd1,
        ST_HDR1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_ready flags the
// cycle in which the final byte of a word is being accepted.
module prog_loader_byte_assembler
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  data_byte,
    output logic [31:0] word,
    output logic        word_ready
);

    localparam int unsigned CNT_W = $clog2(WORD_BYTES);

    logic [CNT_W-1:0] byte_cnt;

    assign word_ready = byte_valid && (byte_cnt == CNT_W'(WORD_BYTES - 1));

    // Insert each byte at its lane; the counter wraps naturally after the last lane.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (byte_valid) begin
            word[8*byte_cnt +: 8] <= data_byte;
            byte_cnt              <= byte_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: header parse, word assembly, imem writes and
// core reset release once the whole image is in place.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Wide enough that BASE_ADDR + N can never wrap.
    localparam int unsigned CHK_W = ADDR_W + 17;

    state_t            state;
    state_t            state_nxt;
    logic [N_W-1:0]    n_words;
    logic [N_W-1:0]    word_cnt;
    logic [ADDR_W-1:0] addr;
    logic [N_W-1:0]    n_hdr;
    logic [CHK_W-1:0]  end_addr;
    logic              xfer;
    logic              load_start;
    logic              too_big;
    logic              last_word;
    logic              word_ready;

    assign xfer       = in_valid && in_ready;
    assign load_start = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign n_hdr      = {in_data, n_words[7:0]};
    assign end_addr   = CHK_W'(BASE_ADDR) + CHK_W'(n_hdr);
    assign too_big    = end_addr > (CHK_W'(1) << ADDR_W);
    assign last_word  = (word_cnt + N_W'(1)) == n_words;

    // Outputs are pure decodes of the state register.
    assign in_ready  = (state == ST_HDR0) || (state == ST_HDR1) || (state == ST_DATA);
    assign busy      = in_ready || (state == ST_WRITE);
    assign imem_we   = (state == ST_WRITE);
    assign core_rst  = (state != ST_DONE);
    assign done      = (state == ST_DONE);
    assign err       = (state == ST_ERR);
    assign imem_addr = addr;

    prog_loader_byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (load_start),
        .byte_valid (xfer && (state == ST_DATA)),
        .data_byte  (in_data),
        .word       (imem_wdata),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_HDR0;
            ST_HDR0:  if (xfer)  state_nxt = ST_HDR1;
            ST_HDR1: begin
                if (xfer) begin
                    if (n_hdr == '0)  state_nxt = ST_DONE;
                    else if (too_big) state_nxt = ST_ERR;
                    else              state_nxt = ST_DATA;
                end
            end
            ST_DATA:  if (word_ready) state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = last_word ? ST_DONE : ST_DATA;
            ST_DONE:  if (start) state_nxt = ST_HDR0;
            ST_ERR:   if (start) state_nxt = ST_HDR0;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Header latch, word counter and write address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_words  <= '0;
            word_cnt <= '0;
            addr     <= ADDR_W'(BASE_ADDR);
        end else if (load_start) begin
            word_cnt <= '0;
            addr     <= ADDR_W'(BASE_ADDR);
        end else if (state == ST_HDR0 && xfer) begin
            n_words[7:0] <= in_data;
        end else if (state == ST_HDR1 && xfer) begin
            n_words[15:8] <= in_data;
        end else if (state == ST_WRITE) begin
            word_cnt <= word_cnt + N_W'(1);
            addr     <= addr + ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: dut_a uses ADDR_W=8, dut_b uses ADDR_W=4.
`timescale 1ns/1ps
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_a = 1'b0, valid_a = 1'b0, start_b = 1'b0, valid_b = 1'b0;
    logic [7:0]  data_a = 8'h00, data_b = 8'h00;
    logic        ready_a, we_a, core_rst_a, busy_a, done_a, err_a;
    logic        ready_b, we_b, core_rst_b, busy_b, done_b, err_b;
    logic [7:0]  addr_a;
    logic [3:0]  addr_b;
    logic [31:0] wdata_a, wdata_b;

    int vec = 0;
    int errs = 0;
    int cyc = 0;
    logic [39:0] wlog_a[$];
    int          wcyc_a[$];
    logic [35:0] wlog_b[$];
    logic [7:0]  stim[$];

    prog_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(valid_a), .in_data(data_a),
        .in_ready(ready_a), .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
        .core_rst(core_rst_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    prog_loader #(.ADDR_W(4), .BASE_ADDR(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(valid_b), .in_data(data_b),
        .in_ready(ready_b), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
        .core_rst(core_rst_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we_a) begin
            wlog_a.push_back({addr_a, wdata_a});
            wcyc_a.push_back(cyc);
        end
        if (we_b) wlog_b.push_back({addr_b, wdata_b});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_logs();
        wlog_a.delete();
        wcyc_a.delete();
        wlog_b.delete();
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Offers stim[] bytes in order; gap>0 inserts 1..gap idle cycles between bytes.
    task automatic send_stream(input bit sel, input int gap);
        for (int i = 0; i < stim.size(); i++) begin
            int t;
            bit got;
            t = 0;
            got = 1'b0;
            if (sel) begin valid_b = 1'b1; data_b = stim[i]; end
            else     begin valid_a = 1'b1; data_a = stim[i]; end
            while (!got && t < 20) begin
                @(negedge clk);
                got = sel ? ready_b : ready_a;
                @(posedge clk); #1;
                t++;
            end
            vec++;
            if (!got) begin
                errs++;
                $display("FAIL stream_accept: byte %0d got no ready in 20 cycles, required accepted", i);
            end
            if (gap > 0 && i != stim.size() - 1) begin
                valid_a = 1'b0;
                valid_b = 1'b0;
                repeat ($urandom_range(gap, 1)) @(posedge clk);
                #1;
            end
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic wait_done(input bit sel);
        int t;
        t = 0;
        while (!(sel ? done_b : done_a) && t < 400) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1;
        vec++;
        if (!(sel ? done_b : done_a)) begin
            errs++;
            $display("FAIL done_wait: done=0 after 400 cycles, required 1");
        end
    endtask

    task automatic test_reset();
        #13;
        vec++;
        if ({ready_a, we_a, core_rst_a, busy_a, done_a, err_a} !== 6'b001000) begin
            errs++;
            $display("FAIL reset_flags_a: got %b required 001000",
                     {ready_a, we_a, core_rst_a, busy_a, done_a, err_a});
        end
        vec++;
        if ({addr_a, wdata_a} !== 40'h0) begin
            errs++;
            $display("FAIL reset_addr_data_a: got %h required 0", {addr_a, wdata_a});
        end
        vec++;
        if ({ready_b, we_b, core_rst_b, busy_b, done_b, err_b, addr_b} !== 10'b0010000000) begin
            errs++;
            $display("FAIL reset_b: got %b required 0010000000",
                     {ready_b, we_b, core_rst_b, busy_b, done_b, err_b, addr_b});
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        clear_logs();
        pulse_start(0);
        stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        send_stream(0, 0);
        @(negedge clk);
        vec++;
        if ({we_a, addr_a, wdata_a} !== {1'b1, 8'h01, 32'h00B00593}) begin
            errs++;
            $display("FAIL basic_last_write: got we=%b addr=%h data=%h required 1/01/00b00593",
                     we_a, addr_a, wdata_a);
        end
        @(negedge clk);
        vec++;
        if ({done_a, core_rst_a, busy_a} !== 3'b100) begin
            errs++;
            $display("FAIL basic_release: got done/core_rst/busy=%b required 100",
                     {done_a, core_rst_a, busy_a});
        end
        @(posedge clk); #1;
        vec++;
        if (wlog_a.size() != 2) begin
            errs++;
            $display("FAIL basic_count: got %0d writes required 2", wlog_a.size());
        end else begin
            vec++;
            if (wlog_a[0] !== 40'h00_00A00513 || wlog_a[1] !== 40'h01_00B00593) begin
                errs++;
                $display("FAIL basic_words: got %h %h required 0000a00513 0100b00593",
                         wlog_a[0], wlog_a[1]);
            end
            vec++;
            if (wcyc_a[1] - wcyc_a[0] != 5) begin
                errs++;
                $display("FAIL basic_throughput: got %0d cycles/word required 5",
                         wcyc_a[1] - wcyc_a[0]);
            end
        end
    endtask

    task automatic test_gaps();
        clear_logs();
        pulse_start(0);
        @(negedge clk);
        vec++;
        if ({core_rst_a, done_a, busy_a} !== 3'b101) begin
            errs++;
            $display("FAIL restart_from_done: got core_rst/done/busy=%b required 101",
                     {core_rst_a, done_a, busy_a});
        end
        @(posedge clk); #1;
        stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        send_stream(0, 3);
        wait_done(0);
        vec++;
        if (wlog_a.size() != 2 || wlog_a[0] !== 40'h00_00A00513 || wlog_a[1] !== 40'h01_00B00593) begin
            errs++;
            $display("FAIL gaps_words: got %0d writes, first %h, required 2 writes 0000a00513 0100b00593",
                     wlog_a.size(), wlog_a.size() > 0 ? wlog_a[0] : 40'h0);
        end
        vec++;
        if (core_rst_a !== 1'b0) begin
            errs++;
            $display("FAIL gaps_core_rst: got %b required 0", core_rst_a);
        end
    endtask

    task automatic test_zero();
        clear_logs();
        pulse_start(0);
        stim = '{8'h00, 8'h00};
        send_stream(0, 0);
        @(negedge clk);
        vec++;
        if ({done_a, core_rst_a, busy_a, we_a} !== 4'b1000) begin
            errs++;
            $display("FAIL zero_done: got done/core_rst/busy/we=%b required 1000",
                     {done_a, core_rst_a, busy_a, we_a});
        end
        repeat (3) @(posedge clk);
        #1;
        vec++;
        if (wlog_a.size() != 0) begin
            errs++;
            $display("FAIL zero_writes: got %0d writes required 0", wlog_a.size());
        end
    endtask

    task automatic test_start_ignored();
        clear_logs();
        pulse_start(0);
        stim = '{8'h02, 8'h00};
        send_stream(0, 0);
        @(negedge clk);
        vec++;
        if ({busy_a, ready_a, done_a} !== 3'b110) begin
            errs++;
            $display("FAIL hdr_latency: got busy/ready/done=%b required 110", {busy_a, ready_a, done_a});
        end
        @(posedge clk); #1;
        stim = '{8'h13, 8'h05};
        send_stream(0, 0);
        pulse_start(0);
        @(negedge clk);
        vec++;
        if ({busy_a, done_a, err_a, ready_a} !== 4'b1001) begin
            errs++;
            $display("FAIL start_in_data: got busy/done/err/ready=%b required 1001",
                     {busy_a, done_a, err_a, ready_a});
        end
        @(posedge clk); #1;
        stim = '{8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        send_stream(0, 0);
        wait_done(0);
        vec++;
        if (wlog_a.size() != 2 || wlog_a[0] !== 40'h00_00A00513 || wlog_a[1] !== 40'h01_00B00593) begin
            errs++;
            $display("FAIL ignored_words: got %0d writes required 2 correct writes", wlog_a.size());
        end
    endtask

    task automatic test_err_recover();
        clear_logs();
        pulse_start(1);
        stim = '{8'h11, 8'h00};
        send_stream(1, 0);
        @(negedge clk);
        vec++;
        if ({err_b, core_rst_b, busy_b, ready_b, done_b} !== 5'b11000) begin
            errs++;
            $display("FAIL err_state: got err/core_rst/busy/ready/done=%b required 11000",
                     {err_b, core_rst_b, busy_b, ready_b, done_b});
        end
        repeat (3) @(posedge clk);
        #1;
        vec++;
        if (wlog_b.size() != 0) begin
            errs++;
            $display("FAIL err_writes: got %0d writes required 0", wlog_b.size());
        end
        pulse_start(1);
        @(negedge clk);
        vec++;
        if ({err_b, busy_b} !== 2'b01) begin
            errs++;
            $display("FAIL err_restart: got err/busy=%b required 01", {err_b, busy_b});
        end
        @(posedge clk); #1;
        stim = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        send_stream(1, 0);
        wait_done(1);
        vec++;
        if (wlog_b.size() != 1 || wlog_b[0] !== 36'h0_12345678 || core_rst_b !== 1'b0) begin
            errs++;
            $display("FAIL err_recover: got %0d writes first %h core_rst=%b required 1 write 012345678 core_rst=0",
                     wlog_b.size(), wlog_b.size() > 0 ? wlog_b[0] : 36'h0, core_rst_b);
        end
    endtask

    task automatic test_max_image();
        clear_logs();
        pulse_start(1);
        stim = '{8'h10, 8'h00};
        for (int w = 0; w < 16; w++) repeat (4) stim.push_back(8'(w));
        send_stream(1, 0);
        wait_done(1);
        vec++;
        if (wlog_b.size() != 16) begin
            errs++;
            $display("FAIL max_count: got %0d writes required 16", wlog_b.size());
        end else begin
            vec++;
            if (wlog_b[0] !== 36'h0_00000000 || wlog_b[7] !== 36'h7_07070707 || wlog_b[15] !== 36'hF_0F0F0F0F) begin
                errs++;
                $display("FAIL max_words: got %h %h %h required 000000000 707070707 f0f0f0f0f",
                         wlog_b[0], wlog_b[7], wlog_b[15]);
            end
        end
        vec++;
        if (addr_b !== 4'h0) begin
            errs++;
            $display("FAIL max_wrap: got addr %h required 0", addr_b);
        end
    endtask

    task automatic test_abort();
        clear_logs();
        pulse_start(0);
        stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05};
        send_stream(0, 0);
        vec++;
        if ({addr_a, busy_a} !== 9'h003) begin
            errs++;
            $display("FAIL abort_pre: got addr/busy=%h required 003", {addr_a, busy_a});
        end
        rst = 1'b0;
        #1;
        vec++;
        if ({ready_a, we_a, core_rst_a, busy_a, done_a, err_a} !== 6'b001000) begin
            errs++;
            $display("FAIL abort_flags: got %b required 001000",
                     {ready_a, we_a, core_rst_a, busy_a, done_a, err_a});
        end
        vec++;
        if ({addr_a, wdata_a} !== 40'h0) begin
            errs++;
            $display("FAIL abort_addr_data: got %h required 0", {addr_a, wdata_a});
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        clear_logs();
        pulse_start(0);
        stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        send_stream(0, 0);
        wait_done(0);
        vec++;
        if (wlog_a.size() != 2 || wlog_a[0] !== 40'h00_00A00513 || wlog_a[1] !== 40'h01_00B00593) begin
            errs++;
            $display("FAIL abort_reload: got %0d writes required 2 correct writes", wlog_a.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_zero();
        test_start_ignored();
        test_err_recover();
        test_max_image();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
